// File: rtl/lsu.sv
// Load/store unit: one request at a time, funct3 -> one-hot ram write enable, load extension.
// Optional `LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of reaching ram.
module lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [2:0]  mem_write_enable_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e      state_q;
    logic        is_store_q;
    logic        fault_q;
    logic [2:0]  funct3_q;
    logic        req_fault_d;
    logic [2:0]  req_we_code_d;
    logic [31:0] load_ext_d;

    // Handshake: a request is taken at a rising edge where req_valid_i & req_ready_o.
    assign req_ready_o = (state_q == IDLE);
    assign dbg_state_o = state_q;

    always_comb begin
        req_fault_d   = 1'b0;
        req_we_code_d = 3'b000;
        if (req_we_i) begin
            case (req_funct3_i)
                3'b000:  req_we_code_d = 3'b100;
                3'b001:  req_we_code_d = 3'b010;
                3'b010:  req_we_code_d = 3'b001;
                default: req_fault_d   = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_fault_d = 1'b0;
                default:                                req_fault_d = 1'b1;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        // funct3[1:0] selects access size for both LH/LHU/SH (01) and LW/SW (10).
        if ((req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
            (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00)) begin
            req_fault_d = 1'b1;
        end
`endif
        if (req_fault_d) begin
            req_we_code_d = 3'b000;
        end
    end

    always_comb begin
        load_ext_d = mem_rdata_i;
        case (funct3_q)
            3'b000:  load_ext_d = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            3'b001:  load_ext_d = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            3'b100:  load_ext_d = {24'b0, mem_rdata_i[7:0]};
            3'b101:  load_ext_d = {16'b0, mem_rdata_i[15:0]};
            default: load_ext_d = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= IDLE;
            is_store_q         <= 1'b0;
            fault_q            <= 1'b0;
            funct3_q           <= 3'b000;
            resp_valid_o       <= 1'b0;
            resp_fault_o       <= 1'b0;
            resp_rdata_o       <= 32'h0;
            mem_write_enable_o <= 3'b000;
            mem_addr_o         <= 32'h0;
            mem_wdata_o        <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        mem_addr_o         <= req_addr_i;
                        mem_wdata_o        <= req_wdata_i;
                        mem_write_enable_o <= req_we_code_d;
                        is_store_q         <= req_we_i;
                        fault_q            <= req_fault_d;
                        funct3_q           <= req_funct3_i;
                        state_q            <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write enable lives exactly one cycle so ram commits once.
                    mem_write_enable_o <= 3'b000;
                    if (fault_q) begin
                        resp_valid_o <= 1'b1;
                        resp_fault_o <= 1'b1;
                        resp_rdata_o <= 32'h0;
                        state_q      <= RESP;
                    end else if (is_store_q) begin
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= 32'h0;
                        state_q      <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= load_ext_d;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_fault_o <= 1'b0;
                    resp_rdata_o <= 32'h0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small byte-addressed ram model (GPIO byte at bit 29 window).
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [2:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    lsu dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_we_i           (req_we),
        .req_funct3_i       (req_funct3),
        .req_addr_i         (req_addr),
        .req_wdata_i        (req_wdata),
        .resp_valid_o       (resp_valid),
        .resp_rdata_o       (resp_rdata),
        .resp_fault_o       (resp_fault),
        .mem_write_enable_o (mem_we),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_rdata_i        (mem_rdata),
        .dbg_state_o        (dbg_state)
    );

    always #5 clk = ~clk;

    // ram model: registered read of the word starting at the byte address.
    logic [7:0] mem [0:1023];
    logic [7:0] gpio = 8'h00;
    logic [9:0] base;
    always @(posedge clk) begin
        base = mem_addr[9:0];
        if (mem_addr[29]) begin
            if (mem_we != 3'b000) gpio <= mem_wdata[7:0];
            mem_rdata <= {24'b0, gpio};
        end else begin
            case (mem_we)
                3'b001: for (int i = 0; i < 4; i++) mem[base + 10'(i)] <= mem_wdata[8*i +: 8];
                3'b010: for (int i = 0; i < 2; i++) mem[base + 10'(i)] <= mem_wdata[8*i +: 8];
                3'b100: mem[base] <= mem_wdata[7:0];
                default: ;
            endcase
            mem_rdata <= {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each response pulse pops {fault, rdata}.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_fault", {31'b0, resp_fault}, {31'b0, e[32]});
                chk("resp_rdata", resp_rdata, e[31:0]);
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic ef, input logic [31:0] er,
                          input int elat, input logic [2:0] ewe);
        int lat;
        int we_cnt;
        int busy_ready;
        int guard;
        logic [2:0] we_val;
        exp_q.push_back({ef, er});
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk({tag, "/ready_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_cnt = 0; we_val = 3'b000; busy_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) chk({tag, "/mem_addr"}, mem_addr, a);
            if (mem_we != 3'b000) begin
                we_cnt++;
                we_val = mem_we;
            end
            if (req_ready !== 1'b0) busy_ready++;
            if (resp_valid === 1'b1) break;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(elat));
        chk({tag, "/we_cycles"}, 32'(we_cnt), (ewe != 3'b000) ? 32'd1 : 32'd0);
        chk({tag, "/we_code"}, {29'b0, we_val}, {29'b0, ewe});
        chk({tag, "/ready_busy"}, 32'(busy_ready), 32'd0);
        @(negedge clk);
        chk({tag, "/pulse_end"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "/rdata_clr"}, resp_rdata, 32'd0);
        chk({tag, "/ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] ra;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {29'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        do_req("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 2, 3'b001);
        do_req("sw_104", 1'b1, 3'b010, 32'h104, 32'h11223344, 1'b0, 32'h0, 2, 3'b001);
        do_req("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 3, 3'b000);
        do_req("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFFFFDE, 3, 3'b000);
        do_req("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h000000DE, 3, 3'b000);
        do_req("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'hFFFFDEAD, 3, 3'b000);
        do_req("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 32'h0000DEAD, 3, 3'b000);
        do_req("lb_100", 1'b0, 3'b000, 32'h100, 32'h0, 1'b0, 32'hFFFFFFEF, 3, 3'b000);
        do_req("lh_104", 1'b0, 3'b001, 32'h104, 32'h0, 1'b0, 32'h00003344, 3, 3'b000);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw_101_trap", 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0, 2, 3'b000);
        do_req("sw_102_trap", 1'b1, 3'b010, 32'h102, 32'h55555555, 1'b1, 32'h0, 2, 3'b000);
        do_req("lw_100_keep", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 3, 3'b000);
        do_req("lhu_101_trap", 1'b0, 3'b101, 32'h101, 32'h0, 1'b1, 32'h0, 2, 3'b000);
`else
        do_req("lw_101_mis", 1'b0, 3'b010, 32'h101, 32'h0, 1'b0, 32'h44DEADBE, 3, 3'b000);
        do_req("sw_102_mis", 1'b1, 3'b010, 32'h102, 32'h55555555, 1'b0, 32'h0, 2, 3'b001);
        do_req("lw_100_mis", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h5555BEEF, 3, 3'b000);
        do_req("sw_100_fix", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 2, 3'b001);
`endif

        do_req("sh_100", 1'b1, 3'b001, 32'h100, 32'hFFFF1234, 1'b0, 32'h0, 2, 3'b010);
        do_req("lw_after_sh", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEAD1234, 3, 3'b000);

        do_req("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 2, 3'b000);
        do_req("ld_f3_110", 1'b0, 3'b110, 32'h100, 32'h0, 1'b1, 32'h0, 2, 3'b000);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 32'h0, 2, 3'b000);
        do_req("lw_after_bad", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEAD1234, 3, 3'b000);

        do_req("sb_gpio", 1'b1, 3'b000, 32'h20000000, 32'h000000A5, 1'b0, 32'h0, 2, 3'b100);
        chk("gpio_value", {24'b0, gpio}, 32'h000000A5);
        do_req("lbu_gpio", 1'b0, 3'b100, 32'h20000000, 32'h0, 1'b0, 32'h000000A5, 3, 3'b000);

        for (int i = 0; i < 4; i++) begin
            rv = $urandom_range(32'h7FFFFFFF, 0) ^ (32'(i) << 31);
            ra = 32'h200 + 32'($urandom_range(63, 0)) * 4;
            do_req("rnd_sw", 1'b1, 3'b010, ra, rv, 1'b0, 32'h0, 2, 3'b001);
            do_req("rnd_lw", 1'b0, 3'b010, ra, 32'h0, 1'b0, rv, 3, 3'b000);
        end

        // Reset while a load waits in WAIT: response is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_state", {30'b0, dbg_state}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wait_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("rst_wait_valid2", {31'b0, resp_valid}, 32'd0);

        // Reset and request at the same edge: not accepted.
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_req_state", {30'b0, dbg_state}, 32'd0);
        chk("rst_req_addr", mem_addr, 32'd0);
        @(negedge clk);
        chk("rst_req_idle", {30'b0, dbg_state}, 32'd0);

        do_req("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEAD1234, 3, 3'b000);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the RISC-V core's execute stage and `ram`. Accepts one load or store request at a time over a valid/ready handshake and decodes RISC-V `funct3` into `ram`'s one-hot `write_enable`. For loads, it waits out `ram`'s one-cycle registered read, then sign- or zero-extends the result and returns it with a one-cycle response pulse.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: high only in IDLE; handshake is `req_valid & req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V `funct3`. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: qualified by `resp_valid`.
- `mem_write_enable` out 3: to `ram.write_enable`. 001 = word, 010 = half, 100 = byte, 000 = none.
- `mem_addr` out 32: to `ram.addr`.
- `mem_wdata` out 32: to `ram.data_in`.
- `mem_rdata` in 32: from `ram.data_out`; already shifted right by the byte offset.

## Operation
- **States:** IDLE, ACCESS, WAIT, RESP. The state and all `mem_*` and `resp_*` outputs are registered.
- **IDLE, on handshake:**
  - Latch the request into `mem_addr` and `mem_wdata`.
  - Decode `mem_write_enable`: stores get the one-hot code; loads get 000.
  - Go to ACCESS.
  - `req_valid` without ready is ignored.
- **ACCESS** (exactly one cycle, so `ram` writes exactly once):
  - Next `mem_write_enable` = 000.
  - Loads go to WAIT; stores go to RESP.
- **WAIT:**
  - `mem_rdata` is valid in this cycle.
  - Register the extended value into `resp_rdata`, then go to RESP.
- **Load extension:**
  - LB: `{{24{d[7]}}, d[7:0]}`.
  - LBU: `{24'b0, d[7:0]}`.
  - LH: `{{16{d[15]}}, d[15:0]}`.
  - LHU: `{16'b0, d[15:0]}`.
  - LW: `d`.
- **RESP:** `resp_valid` = 1 for one cycle, then return to IDLE, which clears `resp_*`. There is no response backpressure; the core must take the pulse.
- **Illegal `funct3`** (load 011/110/111; store 011 or higher):
  - Fault: no memory access, `mem_write_enable` stays 000.
  - Route IDLE → ACCESS → RESP with `resp_fault` = 1 and `resp_rdata` = 0.
- **Address handling:** `mem_addr` passes through unchanged, including bit 29, the I/O window at 0x20000000. Address decode belongs to `ram`.

## Timing
- **Reset values:**
  - State IDLE, so `req_ready` = 1.
  - `resp_valid` = 0, `resp_fault` = 0, `resp_rdata` = 0.
  - `mem_write_enable` = 000, `mem_addr` = 0, `mem_wdata` = 0.
- **Load latency:** handshake at edge E0; `resp_valid` high in the cycle after E2 (the third cycle after E0).
- **Store latency:** `resp_valid` high in the cycle after E1. The `ram` write commits at E1.
- **Throughput:** at most one request per 3 cycles (store) or 4 cycles (load). The next handshake is possible at the edge that ends RESP's successor IDLE cycle.
- **`rst` at any edge:** forces IDLE and the reset values, and discards any in-flight response. If `rst` coincides with E1 of a store, `ram` has already sampled `mem_write_enable` at that edge, so the write commits.
- **`rst` and `req_valid` at the same edge:** the request is not accepted.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - LH/LHU/SH with `addr[0]`=1 fault like an illegal `funct3`.
  - LW/SW with `addr[1:0]`≠0 fault the same way.
  - No memory access occurs.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Misaligned accesses proceed with the address unchanged; the result is whatever `ram` produces for that offset.
  - `resp_fault` is raised only for an illegal `funct3`.

## Test plan
- **Store word:** SW 0x100, data 0xDEADBEEF → `mem_write_enable` = 001 for exactly one cycle; `resp_valid` in the 2nd cycle after the handshake, `resp_fault` = 0.
- **Load word:** LW 0x100 → `resp_rdata` = 0xDEADBEEF in the 3rd cycle after the handshake; `req_ready` low from ACCESS through RESP.
- **Byte and half loads** (memory holds 0xDEADBEEF at 0x100):
  - LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE.
  - LH 0x102 → 0xFFFFDEAD; LHU 0x102 → 0x0000DEAD.
- **Half store:** SH 0x100, data 0x1234, then LW 0x100 → 0xDEAD1234.
- **Faults, macro defined:**
  - LW 0x101 → `resp_fault` = 1, `resp_rdata` = 0, `mem_write_enable` never nonzero.
  - SW 0x102 → fault; a later LW 0x100 is unchanged.
  - Load `funct3` = 011 → fault.
- **GPIO and reset:**
  - SB 0x20000000, data 0xA5 → `ram.gpio` = 0xA5 after the write edge.
  - `rst` pulsed while in WAIT → next cycle `req_ready` = 1, `resp_valid` stays 0.
